bulls_cows_guesser: RTL and testbench



---
 rtl/bc_pkg.sv | 66 ++++++
 rtl/bulls_cows_score.sv | 23 ++
 rtl/bulls_cows_guesser.sv | 163 ++++++++++++++++
 tb/tb_bulls_cows_guesser.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bc_pkg.sv
// rtl/bc_pkg.sv - shared types and odometer helper for the bulls-and-cows guesser
package bc_pkg;

  typedef logic [3:0] digit_t;
  typedef digit_t [3:0] code_t;

  typedef struct packed {
    logic [2:0] a;
    logic [2:0] b;
  } score_t;

  typedef enum logic [2:0] {IDLE, SEARCH, OFFER, WAIT_SCORE, DONE} state_t;

  typedef struct packed {
    logic  exhausted;
    code_t code;
  } next_t;

  localparam digit_t DIGIT_MIN = 4'd1;
  localparam digit_t DIGIT_MAX = 4'd9;

  // Next distinct-digit code after c in odometer order; repeats are jumped over
  // in one step by bumping the lowest digit that can grow and refilling the
  // digits below it with the smallest unused values.
  function automatic next_t next_distinct(input code_t c);
    next_t       r;
    logic [15:0] used;
    logic        hit;
    digit_t      v;
    r.code      = c;
    r.exhausted = 1'b1;
    for (int p = 0; p < 4; p++) begin
      if (r.exhausted) begin
        used = '0;
        for (int q = 0; q < 4; q++) begin
          if (q > p) used[c[2'(q)]] = 1'b1;
        end
        hit = 1'b0;
        v   = '0;
        for (int d = int'(DIGIT_MAX); d >= int'(DIGIT_MIN); d--) begin
          if ((4'(d) > c[2'(p)]) && !used[4'(d)]) begin
            hit = 1'b1;
            v   = 4'(d);
          end
        end
        if (hit) begin
          r.exhausted     = 1'b0;
          r.code[2'(p)]   = v;
          used[v]         = 1'b1;
          for (int q = 3; q >= 0; q--) begin
            if (q < p) begin
              v = '0;
              for (int d = int'(DIGIT_MAX); d >= int'(DIGIT_MIN); d--) begin
                if (!used[4'(d)]) v = 4'(d);
              end
              r.code[2'(q)] = v;
              used[v]       = 1'b1;
            end
          end
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/bulls_cows_score.sv
// rtl/bulls_cows_score.sv - combinational A/B scorer of a candidate against one stored guess
module bulls_cows_score
  import bc_pkg::*;
(
  input  code_t  cand,
  input  code_t  guess,
  output score_t score
);

  // Count same-position matches as A and cross-position matches as B
  always_comb begin
    score = '0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        if (cand[2'(i)] == guess[2'(j)]) begin
          if (i == j) score.a = score.a + 3'd1;
          else        score.b = score.b + 3'd1;
        end
      end
    end
  end

endmodule

// File: rtl/bulls_cows_guesser.sv
// rtl/bulls_cows_guesser.sv - automatic codebreaker offering consistent guesses to a scorer
module bulls_cows_guesser
  import bc_pkg::*;
#(
  parameter int          MAX_GUESSES = 10,
  parameter logic [15:0] FIRST_GUESS = 16'h1234
)
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        guess_valid,
  output logic [15:0] guess_data,
  input  logic        guess_ready,
  input  logic        score_valid,
  input  logic [2:0]  score_a,
  input  logic [2:0]  score_b,
  output logic        busy,
  output logic        solved,
  output logic        fail,
  output logic [3:0]  guess_count
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_GUESSES);

  state_t                 state, state_next;
  code_t                  cand;
  next_t                  nxt;
  code_t                  hist_code  [MAX_GUESSES];
  score_t                 hist_score [MAX_GUESSES];
  logic [MAX_GUESSES-1:0] hist_valid;
  logic [MAX_GUESSES-1:0] match;
  logic                   consistent;
  logic [3:0]             score_sum;

  logic clear_game, load_offer, accept, store_score, advance, set_solved, set_fail;

  assign nxt       = next_distinct(cand);
  assign score_sum = {1'b0, score_a} + {1'b0, score_b};
  assign busy      = (state == SEARCH) || (state == OFFER) || (state == WAIT_SCORE);

  // The candidate is scored against every history slot at once; empty slots always agree
  for (genvar k = 0; k < MAX_GUESSES; k++) begin : g_check
    score_t s;
    bulls_cows_score u_score (
      .cand  (cand),
      .guess (hist_code[k]),
      .score (s)
    );
    assign match[k] = !hist_valid[k] || (s == hist_score[k]);
  end

  assign consistent = &match;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state and datapath strobes; start aborts any game from any state
  always_comb begin
    state_next  = state;
    clear_game  = 1'b0;
    load_offer  = 1'b0;
    accept      = 1'b0;
    store_score = 1'b0;
    advance     = 1'b0;
    set_solved  = 1'b0;
    set_fail    = 1'b0;
    if (start) begin
      clear_game = 1'b1;
      state_next = SEARCH;
    end else begin
      case (state)
        SEARCH: begin
          if (consistent) begin
            load_offer = 1'b1;
            state_next = OFFER;
          end else if (nxt.exhausted) begin
            set_fail   = 1'b1;
            state_next = DONE;
          end else begin
            advance = 1'b1;
          end
        end
        OFFER: begin
          if (guess_ready) begin
            accept     = 1'b1;
            state_next = WAIT_SCORE;
          end
        end
        WAIT_SCORE: begin
          if (score_valid) begin
            store_score = 1'b1;
            if (score_a == 3'd4 && score_b == 3'd0) begin
              set_solved = 1'b1;
              state_next = DONE;
            end else if (score_sum > 4'd4 || score_a == 3'd4) begin
              set_fail   = 1'b1;
              state_next = DONE;
            end else if (guess_count == MAX_CNT || nxt.exhausted) begin
              set_fail   = 1'b1;
              state_next = DONE;
            end else begin
              advance    = 1'b1;
              state_next = SEARCH;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Candidate, offered guess, history and game flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand        <= code_t'(FIRST_GUESS);
      guess_valid <= 1'b0;
      guess_data  <= '0;
      guess_count <= '0;
      solved      <= 1'b0;
      fail        <= 1'b0;
      hist_valid  <= '0;
      for (int k = 0; k < MAX_GUESSES; k++) begin
        hist_code[k]  <= '0;
        hist_score[k] <= '0;
      end
    end else if (clear_game) begin
      cand        <= code_t'(FIRST_GUESS);
      guess_valid <= 1'b0;
      guess_count <= '0;
      solved      <= 1'b0;
      fail        <= 1'b0;
      hist_valid  <= '0;
    end else begin
      if (advance) cand <= nxt.code;
      if (load_offer) begin
        guess_valid <= 1'b1;
        guess_data  <= cand;
      end
      if (accept) begin
        guess_valid <= 1'b0;
        guess_count <= guess_count + 4'd1;
        for (int k = 0; k < MAX_GUESSES; k++) begin
          if (4'(k) == guess_count) hist_code[k] <= cand;
        end
      end
      if (store_score) begin
        for (int k = 0; k < MAX_GUESSES; k++) begin
          if (4'(k) == guess_count - 4'd1) begin
            hist_score[k] <= score_t'({score_a, score_b});
            hist_valid[k] <= 1'b1;
          end
        end
      end
      if (set_solved) solved <= 1'b1;
      if (set_fail)   fail   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bulls_cows_guesser.sv
// tb/tb_bulls_cows_guesser.sv - self-checking bench for bulls_cows_guesser against a decimal reference model
module tb_bulls_cows_guesser;

  localparam int MAXG = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        guess_valid;
  logic [15:0] guess_data;
  logic        guess_ready = 1'b0;
  logic        score_valid = 1'b0;
  logic [2:0]  score_a = '0;
  logic [2:0]  score_b = '0;
  logic        busy, solved, fail;
  logic [3:0]  guess_count;

  int checks = 0;
  int errors = 0;
  int hist_g[$];
  int hist_a[$];
  int hist_b[$];
  int exp_guess = 1234;
  logic [15:0] played[$];

  bulls_cows_guesser #(.MAX_GUESSES(MAXG), .FIRST_GUESS(16'h1234)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .guess_valid(guess_valid), .guess_data(guess_data), .guess_ready(guess_ready),
    .score_valid(score_valid), .score_a(score_a), .score_b(score_b),
    .busy(busy), .solved(solved), .fail(fail), .guess_count(guess_count)
  );

  always #5 clk = ~clk;

  initial begin
    #(900_000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int dig(input int n, input int i);
    int p = 1;
    for (int k = 0; k < i; k++) p *= 10;
    return (n / p) % 10;
  endfunction

  function automatic bit legal_dec(input int n);
    if (n < 1000 || n > 9999) return 0;
    for (int i = 0; i < 4; i++) begin
      if (dig(n, i) == 0) return 0;
      for (int j = i + 1; j < 4; j++) if (dig(n, i) == dig(n, j)) return 0;
    end
    return 1;
  endfunction

  function automatic void score_of(input int c, input int g, output int a, output int b);
    a = 0;
    b = 0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        if (dig(c, i) == dig(g, j)) begin
          if (i == j) a++;
          else        b++;
        end
  endfunction

  function automatic bit consistent(input int c);
    int a, b;
    foreach (hist_g[k]) begin
      score_of(c, hist_g[k], a, b);
      if (a != hist_a[k] || b != hist_b[k]) return 0;
    end
    return 1;
  endfunction

  function automatic int next_consistent(input int from);
    for (int n = from; n <= 9876; n++) if (legal_dec(n) && consistent(n)) return n;
    return -1;
  endfunction

  function automatic int to_hex(input int n);
    if (n < 0) return -1;
    return (dig(n, 3) << 12) | (dig(n, 2) << 8) | (dig(n, 1) << 4) | dig(n, 0);
  endfunction

  function automatic int from_hex(input logic [15:0] h);
    return int'(h[15:12]) * 1000 + int'(h[11:8]) * 100 + int'(h[7:4]) * 10 + int'(h[3:0]);
  endfunction

  function automatic bit hex_legal(input logic [15:0] h);
    logic [3:0] d [4];
    for (int i = 0; i < 4; i++) d[i] = h[4*i +: 4];
    for (int i = 0; i < 4; i++) begin
      if (d[i] < 4'd1 || d[i] > 4'd9) return 0;
      for (int j = i + 1; j < 4; j++) if (d[i] == d[j]) return 0;
    end
    return 1;
  endfunction

  // Every offered guess must be the model's next consistent candidate with legal digits
  always @(negedge clk) begin
    if (guess_valid) begin
      check("guess_data_model", int'(guess_data), to_hex(exp_guess));
      check("guess_digits_legal", int'(hex_legal(guess_data)), 1);
    end
  end

  task automatic clear_model();
    hist_g.delete();
    hist_a.delete();
    hist_b.delete();
    played.delete();
  endtask

  task automatic do_start();
    start = 1'b1;
    clear_model();
    exp_guess = next_consistent(1234);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_guess(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (guess_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("guess_timeout", int'(guess_valid), 1);
  endtask

  task automatic accept();
    guess_ready = 1'b1;
    @(negedge clk);
    guess_ready = 1'b0;
    check("valid_drop", int'(guess_valid), 0);
  endtask

  task automatic send_score(input int a, input int b);
    score_valid = 1'b1;
    score_a = 3'(a);
    score_b = 3'(b);
    @(negedge clk);
    score_valid = 1'b0;
  endtask

  task automatic wait_fail();
    for (int i = 0; i < 4000 && !fail; i++) @(negedge clk);
    check("fail_flag", int'(fail), 1);
    check("fail_busy", int'(busy), 0);
    check("fail_solved", int'(solved), 0);
  endtask

  task automatic play_game(input int secret, input bit rand_delay);
    int g, a, b, n;
    bit ok;
    do_start();
    n = 0;
    forever begin
      wait_guess(ok);
      if (!ok) return;
      g = from_hex(guess_data);
      played.push_back(guess_data);
      check("consistent_prior", int'(consistent(g)), 1);
      if (rand_delay) repeat ($urandom_range(0, 3)) @(negedge clk);
      accept();
      n++;
      check("guess_count", int'(guess_count), n);
      score_of(g, secret, a, b);
      if (rand_delay) repeat ($urandom_range(0, 2)) @(negedge clk);
      if (a == 4) begin
        send_score(a, b);
        check("solved_flag", int'(solved), 1);
        check("solved_busy", int'(busy), 0);
        check("solved_fail", int'(fail), 0);
        return;
      end
      hist_g.push_back(g);
      hist_a.push_back(a);
      hist_b.push_back(b);
      if (n == MAXG) begin
        send_score(a, b);
        check("giveup_fail", int'(fail), 1);
        check("giveup_busy", int'(busy), 0);
        return;
      end
      exp_guess = next_consistent(g + 1);
      send_score(a, b);
      if (exp_guess < 0) begin
        wait_fail();
        return;
      end
    end
  endtask

  initial begin
    bit ok;
    int secret;

    repeat (2) @(negedge clk);
    check("rst_guess_valid", int'(guess_valid), 0);
    check("rst_guess_data", int'(guess_data), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_solved", int'(solved), 0);
    check("rst_fail", int'(fail), 0);
    check("rst_guess_count", int'(guess_count), 0);
    rst_n = 1'b1;
    @(negedge clk);

    do_start();
    check("lat_c1_valid", int'(guess_valid), 0);
    check("lat_c1_busy", int'(busy), 1);
    @(negedge clk);
    check("lat_c2_valid", int'(guess_valid), 1);
    check("first_guess", int'(guess_data), 'h1234);
    accept();
    send_score(4, 0);
    check("quick_solved", int'(solved), 1);
    check("quick_count", int'(guess_count), 1);
    check("quick_busy", int'(busy), 0);

    play_game(9527, 1'b0);
    check("g9527_second", (played.size() > 1) ? int'(played[1]) : -1, 'h2567);
    check("g9527_solved", int'(solved), 1);

    do_start();
    wait_guess(ok);
    for (int i = 0; i < 5; i++) begin
      score_valid = (i == 2);
      score_a = 3'd4;
      score_b = 3'd0;
      @(negedge clk);
      check("hold_valid", int'(guess_valid), 1);
      check("hold_data", int'(guess_data), 'h1234);
      check("hold_solved", int'(solved), 0);
    end
    guess_ready = 1'b1;
    score_valid = 1'b1;
    @(negedge clk);
    guess_ready = 1'b0;
    score_valid = 1'b0;
    check("hs_score_ignored", int'(solved), 0);
    check("hs_busy", int'(busy), 1);
    send_score(4, 0);
    check("hold_end_solved", int'(solved), 1);
    check("hold_end_count", int'(guess_count), 1);

    do_start();
    wait_guess(ok);
    accept();
    send_score(3, 2);
    check("bad_score_fail", int'(fail), 1);
    check("bad_score_busy", int'(busy), 0);

    do_start();
    wait_guess(ok);
    accept();
    hist_g.push_back(1234); hist_a.push_back(0); hist_b.push_back(0);
    exp_guess = next_consistent(1235);
    send_score(0, 0);
    wait_guess(ok);
    check("contra_second", int'(guess_data), 'h5678);
    accept();
    hist_g.push_back(5678); hist_a.push_back(0); hist_b.push_back(0);
    exp_guess = next_consistent(5679);
    send_score(0, 0);
    wait_fail();
    check("contra_count", int'(guess_count), 2);

    do_start();
    wait_guess(ok);
    accept();
    hist_g.push_back(1234); hist_a.push_back(0); hist_b.push_back(0);
    exp_guess = next_consistent(1235);
    send_score(0, 0);
    repeat (3) @(negedge clk);
    check("midsearch_busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("arst_guess_valid", int'(guess_valid), 0);
    check("arst_guess_data", int'(guess_data), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_count", int'(guess_count), 0);
    check("arst_fail", int'(fail), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_start();
    wait_guess(ok);
    check("restart_guess", int'(guess_data), 'h1234);
    check("restart_count", int'(guess_count), 0);
    accept();
    check("abort_pre_count", int'(guess_count), 1);
    do_start();
    check("abort_count", int'(guess_count), 0);
    check("abort_busy", int'(busy), 1);
    wait_guess(ok);
    check("abort_guess", int'(guess_data), 'h1234);
    accept();
    send_score(4, 0);
    check("abort_solved", int'(solved), 1);

    for (int gm = 0; gm < 3; gm++) begin
      do secret = $urandom_range(1234, 9876); while (!legal_dec(secret));
      play_game(secret, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
